// File: rtl/pwm_cic_demod_pkg.sv
// ---------------------------------------------------------------------------
// pwm_cic_demod_pkg
// Shared constants, width helper and default word types for the PWM CIC
// demodulator (pwm_width_counter, pwm_cic_demodulator).
// No ports.
// ---------------------------------------------------------------------------
package pwm_cic_demod_pkg;

    localparam int CIC_ORDER      = 3;
    localparam int WARMUP_STROBES = 3;

    localparam int PWM_BITS_DEF   = 7;
    localparam int LOG2_R_MAX_DEF = 4;
    localparam int OUT_BITS_DEF   = 16;

    // Integrator word: width of w plus CIC growth of order*log2(R_max) bits.
    function automatic int acc_bits(input int pwm_bits, input int log2_r_max);
        return pwm_bits + 1 + CIC_ORDER * log2_r_max;
    endfunction

    localparam int ACC_BITS_DEF = acc_bits(PWM_BITS_DEF, LOG2_R_MAX_DEF);

    typedef logic [PWM_BITS_DEF:0]   width_t;
    typedef logic [ACC_BITS_DEF-1:0] acc_t;

endpackage

// File: rtl/pwm_cic_demodulator_if.sv
// ---------------------------------------------------------------------------
// pwm_cic_demodulator_if
// Output sample stream of the demodulator with its valid/ready handshake and
// sticky overrun flag.
//   sample        decimated sample (unsigned, left-aligned)
//   sample_valid  sample holds unconsumed data
//   sample_ready  consumer accepts when valid && ready
//   overrun       sticky, an unconsumed sample was overwritten
//   clear_overrun clears overrun
// modport master: demodulator side; modport slave: consumer side.
// ---------------------------------------------------------------------------
interface pwm_cic_demodulator_if #(
    parameter int OUT_BITS = 16
) ();
    logic [OUT_BITS-1:0] sample;
    logic                sample_valid;
    logic                sample_ready;
    logic                overrun;
    logic                clear_overrun;

    modport master (
        output sample, sample_valid, overrun,
        input  sample_ready, clear_overrun
    );

    modport slave (
        input  sample, sample_valid, overrun,
        output sample_ready, clear_overrun
    );
endinterface

// File: rtl/pwm_width_counter.sv
// ---------------------------------------------------------------------------
// pwm_width_counter
// Measures the high time of each PWM period (period = compare_max+1 cycles).
// Optional macro PWM_CIC_DEMOD_SYNC_EN: pwm_in passes a 2-flop synchronizer
// (2 clk extra latency, pwm_in may be asynchronous). i_sync is never
// synchronized.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_en             0 freezes all state
//   i_pwm_in         PWM bitstream
//   i_sync           discard partial period, restart period counter
//   i_compare_max    last period count value
//   o_width          high count of the ending period (valid with done)
//   o_period_done    one-cycle strobe on the last cycle of a period
// ---------------------------------------------------------------------------
module pwm_width_counter
    import pwm_cic_demod_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_en,
    input  logic                i_pwm_in,
    input  logic                i_sync,
    input  logic [PWM_BITS-1:0] i_compare_max,
    output logic [PWM_BITS:0]   o_width,
    output logic                o_period_done
);

    logic                w_pwm;
    logic                w_end;
    logic [PWM_BITS-1:0] r_pcnt;
    logic [PWM_BITS:0]   r_hcnt;

`ifdef PWM_CIC_DEMOD_SYNC_EN
    logic r_pwm_meta;
    logic r_pwm_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_meta <= 1'b0;
            r_pwm_sync <= 1'b0;
        end else if (i_en) begin
            r_pwm_meta <= i_pwm_in;
            r_pwm_sync <= r_pwm_meta;
        end
    end

    assign w_pwm = r_pwm_sync;
`else
    assign w_pwm = i_pwm_in;
`endif

    // >= rather than == so a compare_max lowered mid-period still ends it.
    assign w_end         = (r_pcnt >= i_compare_max);
    assign o_period_done = i_en && !i_sync && w_end;
    assign o_width       = r_hcnt + {{PWM_BITS{1'b0}}, w_pwm};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end else if (i_en) begin
            if (i_sync || w_end) begin
                r_pcnt <= '0;
                r_hcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
                r_hcnt <= r_hcnt + {{PWM_BITS{1'b0}}, w_pwm};
            end
        end
    end

endmodule

// File: rtl/pwm_cic_demodulator.sv
// ---------------------------------------------------------------------------
// pwm_cic_demodulator
// Receive end of the noise-shaping PWM DAC path: per-period pulse widths are
// decimated by R = 2^log2_r with a 3rd-order CIC into left-aligned samples.
// Optional macro PWM_CIC_DEMOD_SYNC_EN (see pwm_width_counter).
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_en             0 freezes state (an output accept is still honoured)
//   i_pwm_in         PWM bitstream
//   i_sync           realign period counter, partial period discarded
//   i_compare_max    period = compare_max+1 cycles
//   i_log2_r         decimation exponent, clamped to LOG2_R_MAX
//   o_smp            output sample stream (master modport)
// ---------------------------------------------------------------------------
module pwm_cic_demodulator
    import pwm_cic_demod_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int LOG2_R_MAX = LOG2_R_MAX_DEF,
    parameter int OUT_BITS   = OUT_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_en,
    input  logic                   i_pwm_in,
    input  logic                   i_sync,
    input  logic [PWM_BITS-1:0]    i_compare_max,
    input  logic [2:0]             i_log2_r,
    pwm_cic_demodulator_if.master  o_smp
);

    localparam int ACC_BITS  = acc_bits(PWM_BITS, LOG2_R_MAX);
    localparam int DCNT_BITS = LOG2_R_MAX + 1;
    localparam int WARM_BITS = $clog2(WARMUP_STROBES + 1);

    logic [PWM_BITS:0]     w_width;
    logic                  w_period_done;

    logic [ACC_BITS-1:0]   r_int1, r_int2, r_int3;
    logic [ACC_BITS-1:0]   r_dly1, r_dly2, r_dly3;
    logic [ACC_BITS-1:0]   w_int1_n, w_int2_n, w_int3_n;
    logic [ACC_BITS-1:0]   w_c1, w_c2, w_c3, w_y;
    logic [5:0]            w_shamt;

    logic [2:0]            w_log2_r_clamp;
    logic [2:0]            r_log2_r_eff;
    logic [DCNT_BITS-1:0]  r_dcnt;
    logic [DCNT_BITS-1:0]  w_dcnt_term;
    logic [WARM_BITS-1:0]  r_warm;
    logic                  w_dec;
    logic                  w_new_sample;
    logic                  w_accept;

    logic [OUT_BITS-1:0]   r_sample;
    logic                  r_valid;
    logic                  r_overrun;

    pwm_width_counter #(.PWM_BITS(PWM_BITS)) u_width (
        .clk           (clk),
        .reset         (reset),
        .i_en          (i_en),
        .i_pwm_in      (i_pwm_in),
        .i_sync        (i_sync),
        .i_compare_max (i_compare_max),
        .o_width       (w_width),
        .o_period_done (w_period_done)
    );

    assign w_log2_r_clamp = (i_log2_r > 3'(LOG2_R_MAX)) ? 3'(LOG2_R_MAX) : i_log2_r;
    assign w_dcnt_term    = DCNT_BITS'((32'd1 << r_log2_r_eff) - 32'd1);
    assign w_dec          = w_period_done && (r_dcnt >= w_dcnt_term);

    // Integrators chained without pipeline delay so the combs see the sum
    // including the width that completes this decimation group.
    assign w_int1_n = r_int1 + {{(ACC_BITS-PWM_BITS-1){1'b0}}, w_width};
    assign w_int2_n = r_int2 + w_int1_n;
    assign w_int3_n = r_int3 + w_int2_n;

    assign w_c1 = w_int3_n - r_dly1;
    assign w_c2 = w_c1 - r_dly2;
    assign w_c3 = w_c2 - r_dly3;

    // Gain R^3 is normalised to R_max^3 so full scale is independent of R.
    assign w_shamt = 6'(CIC_ORDER * (LOG2_R_MAX - int'(r_log2_r_eff)));
    assign w_y     = w_c3 << w_shamt;

    // The strobe that latches a new exponent still carries old-R scaling,
    // so it is suppressed along with the following warmup strobes.
    assign w_new_sample = w_dec && (r_warm == WARM_BITS'(WARMUP_STROBES))
                          && (w_log2_r_clamp == r_log2_r_eff);
    assign w_accept     = r_valid && o_smp.sample_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_int1       <= '0;
            r_int2       <= '0;
            r_int3       <= '0;
            r_dly1       <= '0;
            r_dly2       <= '0;
            r_dly3       <= '0;
            r_dcnt       <= '0;
            r_warm       <= '0;
            // Take the exponent during reset so the first group already
            // uses the configured R.
            r_log2_r_eff <= w_log2_r_clamp;
        end else if (w_period_done) begin
            r_int1 <= w_int1_n;
            r_int2 <= w_int2_n;
            r_int3 <= w_int3_n;
            if (w_dec) begin
                r_dcnt       <= '0;
                r_dly1       <= w_int3_n;
                r_dly2       <= w_c1;
                r_dly3       <= w_c2;
                r_log2_r_eff <= w_log2_r_clamp;
                if (w_log2_r_clamp != r_log2_r_eff)
                    r_warm <= '0;
                else if (r_warm != WARM_BITS'(WARMUP_STROBES))
                    r_warm <= r_warm + 1'b1;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_new_sample) begin
                r_sample <= OUT_BITS'(w_y >> (ACC_BITS - OUT_BITS));
                r_valid  <= 1'b1;
            end else if (w_accept) begin
                r_valid  <= 1'b0;
            end
            // Setting wins over a simultaneous clear.
            if (w_new_sample && r_valid && !o_smp.sample_ready)
                r_overrun <= 1'b1;
            else if (i_en && o_smp.clear_overrun)
                r_overrun <= 1'b0;
        end
    end

    assign o_smp.sample       = r_sample;
    assign o_smp.sample_valid = r_valid;
    assign o_smp.overrun      = r_overrun;

endmodule

// File: tb/tb_pwm_cic_demodulator.sv
module tb_pwm_cic_demodulator;
    import pwm_cic_demod_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       pwm = 1'b0;
    logic       sync = 1'b0;
    logic [6:0] cmax = 7'd63;
    logic [2:0] l2r = 3'd2;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    pwm_cic_demodulator_if #(.OUT_BITS(16)) bus ();

    pwm_cic_demodulator dut (
        .clk           (clk),
        .reset         (reset),
        .i_en          (en),
        .i_pwm_in      (pwm),
        .i_sync        (sync),
        .i_compare_max (cmax),
        .i_log2_r      (l2r),
        .o_smp         (bus)
    );

    typedef struct {
        logic [6:0]  cm;
        int          high;
        logic [2:0]  l;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [6:0] cm, input logic [2:0] l);
        reset = 1'b1;
        en = 1'b1;
        sync = 1'b0;
        pwm = 1'b0;
        cmax = cm;
        l2r = l;
        bus.sample_ready = 1'b1;
        bus.clear_overrun = 1'b0;
        repeat (3) tick();
        check("reset sample", bus.sample, 0);
        check("reset valid", bus.sample_valid, 0);
        check("reset overrun", bus.overrun, 0);
        reset = 1'b0;
    endtask

    // Constant width w from reset: settled output is w*R^3 << 3*(4-l) taken
    // from bits [19:4], i.e. w*256 for every R.
    task automatic run_vec(input vec_t v, input int pre_sync, input string tag);
        int leff, per, grp, pre;
        bit seen;
        leff = (v.l > 3'd4) ? 4 : int'(v.l);
        per  = int'(v.cm) + 1;
        grp  = per << leff;
        pre  = 0;
        seen = 1'b0;
        do_reset(v.cm, v.l);
        exp_q.delete();
        if (pre_sync > 0) begin
            pwm = 1'b1;
            repeat (pre_sync) tick();
            sync = 1'b1;
            tick();
            sync = 1'b0;
            pre = pre_sync + 1;
        end
        for (int k = 0; k < 6 * grp + 3; k++) begin
            pwm = ((k % per) < v.high);
            if (((k + 1) % grp == 0) && ((k + 1) / grp >= 4))
                exp_q.push_back(v.exp);
            tick();
            if (bus.sample_valid && bus.sample_ready) begin
                if (!seen) begin
                    seen = 1'b1;
                    check({tag, " first-valid latency"}, pre + k + 1, pre + 4 * grp);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s unexpected sample: got 0x%0h required none", tag, bus.sample);
                end else begin
                    check({tag, " sample"}, bus.sample, exp_q.pop_front());
                end
            end
        end
        check({tag, " any output"}, seen, 1);
        check({tag, " pending expected"}, exp_q.size(), 0);
    endtask

    initial begin
        int seen_e;
        int early;
        bus.sample_ready = 1'b1;
        bus.clear_overrun = 1'b0;

        vecs[0] = '{7'd63,   0, 3'd2, 16'h0000};
        vecs[1] = '{7'd63,  64, 3'd2, 16'h4000};
        vecs[2] = '{7'd63,  16, 3'd2, 16'h1000};
        vecs[3] = '{7'd127, 128, 3'd2, 16'h8000};
        vecs[4] = '{7'd0,    1, 3'd0, 16'h0100};
        vecs[5] = '{7'd0,    0, 3'd1, 16'h0000};
        vecs[6] = '{7'd63,  40, 3'd7, 16'h2800};
        vecs[7] = '{7'd31,   5, 3'd3, 16'h0500};
        vecs[8] = '{7'd63,  64, 3'd5, 16'h4000};
        vecs[9] = '{7'd63,  16, 3'd2, 16'h1000};

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], 0, $sformatf("vec%0d", i));

        // sync at pcnt=30: partial period dropped, first valid 31+1024 edges
        run_vec(vecs[9], 30, "sync");

        // handshake corners with R=1, period 1: sample = pwm of that cycle << 8
        do_reset(7'd0, 3'd0);
        bus.sample_ready = 1'b0;
        pwm = 1'b0;
        repeat (3) tick();
        check("hs warmup valid", bus.sample_valid, 0);
        tick();
        check("hs first valid", bus.sample_valid, 1);
        check("hs first sample", bus.sample, 16'h0000);
        check("hs first overrun", bus.overrun, 0);
        pwm = 1'b1;
        tick();
        check("hs overwrite overrun", bus.overrun, 1);
        check("hs overwrite sample", bus.sample, 16'h0100);
        pwm = 1'b0;
        bus.sample_ready = 1'b1;
        bus.clear_overrun = 1'b1;
        tick();
        check("hs accept+new valid", bus.sample_valid, 1);
        check("hs accept+new overrun", bus.overrun, 0);
        check("hs accept+new sample", bus.sample, 16'h0000);
        pwm = 1'b1;
        bus.sample_ready = 1'b0;
        tick();
        check("hs set beats clear", bus.overrun, 1);
        check("hs set beats clear sample", bus.sample, 16'h0100);
        en = 1'b0;
        pwm = 1'b0;
        tick();
        check("hs en0 overrun held", bus.overrun, 1);
        check("hs en0 valid held", bus.sample_valid, 1);
        bus.clear_overrun = 1'b0;
        bus.sample_ready = 1'b1;
        tick();
        check("hs en0 accept", bus.sample_valid, 0);
        tick();
        check("hs en0 no new sample", bus.sample_valid, 0);
        en = 1'b1;
        pwm = 1'b1;
        bus.clear_overrun = 1'b1;
        bus.sample_ready = 1'b0;
        tick();
        check("hs resume valid", bus.sample_valid, 1);
        check("hs resume sample", bus.sample, 16'h0100);
        check("hs resume overrun", bus.overrun, 0);
        bus.clear_overrun = 1'b0;

        // log2_r 2->1 during group 6: latched at edge 1536, then 3 strobes
        // of 128 clk skipped, next valid at edge 2048
        do_reset(7'd63, 3'd2);
        pwm = 1'b1;
        seen_e = 0;
        early = 0;
        for (int e = 1; e <= 2200; e++) begin
            if (e == 1300)
                l2r = 3'd1;
            tick();
            if (bus.sample_valid && e > 1300) begin
                if (seen_e == 0) begin
                    seen_e = e;
                    check("lr change sample", bus.sample, 16'h4000);
                end
            end else if (bus.sample_valid && e != 1024 && e != 1280) begin
                early++;
            end
        end
        check("lr change first valid edge", seen_e, 2048);
        check("lr change stray valids", early, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
